// File: rtl/apb_pipeline_pkg.sv
// Shared types and helpers for the APB write-posting pipeline.
package apb_pipeline_pkg;

  // South-port transfer state
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  // Width of the per-entry delay down-counter able to hold DELAY
  function automatic int delay_cnt_w(input int delay);
    if (delay < 2) begin
      return 1;
    end else begin
      return $clog2(delay + 1);
    end
  endfunction

endpackage

// File: rtl/apb_posted_fifo.sv
// Posted-write FIFO: entry storage, wrapping pointers, occupancy count and
// a per-entry saturating delay counter.  head_ready goes high once the
// oldest entry has aged enough for the south FSM to start its SETUP.
module apb_posted_fifo
  import apb_pipeline_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int DELAY  = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [ADDR_W-1:0]        push_addr,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [ADDR_W-1:0]        head_addr,
  output logic [DATA_W-1:0]        head_data,
  output logic                     head_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = PW + 1;
  localparam int DLY_W = delay_cnt_w(DELAY);
  // The FSM decides one cycle before SETUP is visible, and the counter is
  // first seen one cycle after the push, hence DELAY-2.
  localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'(DELAY - 2);
  localparam logic [CW-1:0]    DEPTH_C  = CW'(DEPTH);

  logic [ADDR_W-1:0] addr_mem_r [DEPTH];
  logic [DATA_W-1:0] data_mem_r [DEPTH];
  logic [DLY_W-1:0]  dly_r      [DEPTH];
  logic [PW-1:0]     wr_ptr_r;
  logic [PW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;
  logic              push_ok_s;
  logic              pop_ok_s;

  assign push_ok_s = push & (count_r != DEPTH_C);
  assign pop_ok_s  = pop & (count_r != {CW{1'b0}});

  // Entry storage and per-entry delay countdown (saturates at zero)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem_r[i] <= {ADDR_W{1'b0}};
        data_mem_r[i] <= {DATA_W{1'b0}};
        dly_r[i]      <= {DLY_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push_ok_s && (wr_ptr_r == PW'(i))) begin
          addr_mem_r[i] <= push_addr;
          data_mem_r[i] <= push_data;
          dly_r[i]      <= DLY_LOAD;
        end else if (dly_r[i] != {DLY_W{1'b0}}) begin
          dly_r[i] <= dly_r[i] - DLY_W'(1);
        end
      end
    end
  end

  // Read/write pointers (wrap modulo DEPTH) and occupancy count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign head_addr  = addr_mem_r[rd_ptr_r];
  assign head_data  = data_mem_r[rd_ptr_r];
  assign head_ready = (count_r != {CW{1'b0}}) && (dly_r[rd_ptr_r] == {DLY_W{1'b0}});
  assign count      = count_r;

endmodule

// File: rtl/apb_posted_pipeline.sv
// APB write-posting pipeline.  North writes are posted into a FIFO and
// replayed on the south port no earlier than DELAY cycles after acceptance;
// north reads wait for the FIFO to drain and then run non-posted.
// Optional build macro APB_PIPE_WERR_EN adds a sticky south write-error
// capture (werr_clr / werr_sticky / werr_addr).
module apb_posted_pipeline
  import apb_pipeline_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int DELAY  = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   n_psel,
  input  logic                   n_penable,
  input  logic                   n_pwrite,
  input  logic [ADDR_W-1:0]      n_paddr,
  input  logic [DATA_W-1:0]      n_pwdata,
  output logic                   n_pready,
  output logic [DATA_W-1:0]      n_prdata,
  output logic                   n_pslverr,
  output logic                   s_psel,
  output logic                   s_penable,
  output logic                   s_pwrite,
  output logic [ADDR_W-1:0]      s_paddr,
  output logic [DATA_W-1:0]      s_pwdata,
  input  logic                   s_pready,
  input  logic [DATA_W-1:0]      s_prdata,
  input  logic                   s_pslverr,
`ifdef APB_PIPE_WERR_EN
  input  logic                   werr_clr,
  output logic                   werr_sticky,
  output logic [ADDR_W-1:0]      werr_addr,
`endif
  output logic [$clog2(DEPTH):0] count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  apb_state_e        state_r;
  apb_state_e        state_nxt_s;
  logic [CW-1:0]     count_s;
  logic              head_ready_s;
  logic [ADDR_W-1:0] head_addr_s;
  logic [DATA_W-1:0] head_data_s;
  logic              wr_access_s;
  logic              rd_access_s;
  logic              not_full_s;
  logic              push_s;
  logic              start_wr_s;
  logic              start_rd_s;
  logic              done_s;
  logic              pop_s;

  logic              s_psel_r;
  logic              s_penable_r;
  logic              s_pwrite_r;
  logic [ADDR_W-1:0] s_paddr_r;
  logic [DATA_W-1:0] s_pwdata_r;
  logic              psel_nxt_s;
  logic              penable_nxt_s;
  logic              pwrite_nxt_s;
  logic [ADDR_W-1:0] paddr_nxt_s;
  logic [DATA_W-1:0] pwdata_nxt_s;

  logic [DATA_W-1:0] rdata_r;
  logic              rerr_r;

  // North access decode; psel without penable is ignored
  assign wr_access_s = n_psel & n_penable & n_pwrite;
  assign rd_access_s = n_psel & n_penable & ~n_pwrite;
  assign not_full_s  = (count_s != DEPTH_C);
  assign push_s      = wr_access_s & not_full_s;

  // Posted writes win over a waiting read; a read only starts once drained
  assign start_wr_s = (state_r == IDLE) & head_ready_s;
  assign start_rd_s = (state_r == IDLE) & ~head_ready_s & rd_access_s &
                      (count_s == {CW{1'b0}});
  assign done_s     = (state_r == ACCESS) & s_pready;
  assign pop_s      = done_s & s_pwrite_r;

  apb_posted_fifo #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .DELAY  (DELAY)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (push_s),
    .push_addr  (n_paddr),
    .push_data  (n_pwdata),
    .pop        (pop_s),
    .head_addr  (head_addr_s),
    .head_data  (head_data_s),
    .head_ready (head_ready_s),
    .count      (count_s)
  );

  // South FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // South FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_wr_s || start_rd_s) begin
          state_nxt_s = SETUP;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SETUP: state_nxt_s = ACCESS;
      ACCESS: begin
        if (s_pready) begin
          state_nxt_s = s_pwrite_r ? IDLE : RESP;
        end else begin
          state_nxt_s = ACCESS;
        end
      end
      RESP:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // South bus values for the next cycle, derived from the next state
  always_comb begin
    psel_nxt_s    = 1'b0;
    penable_nxt_s = 1'b0;
    pwrite_nxt_s  = 1'b0;
    paddr_nxt_s   = {ADDR_W{1'b0}};
    pwdata_nxt_s  = {DATA_W{1'b0}};
    case (state_nxt_s)
      SETUP: begin
        psel_nxt_s = 1'b1;
        if (state_r == IDLE) begin
          if (start_wr_s) begin
            pwrite_nxt_s = 1'b1;
            paddr_nxt_s  = head_addr_s;
            pwdata_nxt_s = head_data_s;
          end else begin
            pwrite_nxt_s = 1'b0;
            paddr_nxt_s  = n_paddr;
            pwdata_nxt_s = {DATA_W{1'b0}};
          end
        end else begin
          pwrite_nxt_s = s_pwrite_r;
          paddr_nxt_s  = s_paddr_r;
          pwdata_nxt_s = s_pwdata_r;
        end
      end
      ACCESS: begin
        psel_nxt_s    = 1'b1;
        penable_nxt_s = 1'b1;
        pwrite_nxt_s  = s_pwrite_r;
        paddr_nxt_s   = s_paddr_r;
        pwdata_nxt_s  = s_pwdata_r;
      end
      default: begin
        psel_nxt_s    = 1'b0;
        penable_nxt_s = 1'b0;
      end
    endcase
  end

  // Registered south bus outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_psel_r    <= 1'b0;
      s_penable_r <= 1'b0;
      s_pwrite_r  <= 1'b0;
      s_paddr_r   <= {ADDR_W{1'b0}};
      s_pwdata_r  <= {DATA_W{1'b0}};
    end else begin
      s_psel_r    <= psel_nxt_s;
      s_penable_r <= penable_nxt_s;
      s_pwrite_r  <= pwrite_nxt_s;
      s_paddr_r   <= paddr_nxt_s;
      s_pwdata_r  <= pwdata_nxt_s;
    end
  end

  // Capture south read response for the RESP cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_r <= {DATA_W{1'b0}};
      rerr_r  <= 1'b0;
    end else if (done_s && !s_pwrite_r) begin
      rdata_r <= s_prdata;
      rerr_r  <= s_pslverr;
    end
  end

`ifdef APB_PIPE_WERR_EN
  logic              werr_sticky_r;
  logic [ADDR_W-1:0] werr_addr_r;
  logic              werr_set_s;

  assign werr_set_s = pop_s & s_pslverr;

  // Sticky south write-error capture; a failure in the clear cycle wins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      werr_sticky_r <= 1'b0;
      werr_addr_r   <= {ADDR_W{1'b0}};
    end else if (werr_set_s) begin
      werr_sticky_r <= 1'b1;
      if (!werr_sticky_r || werr_clr) begin
        werr_addr_r <= s_paddr_r;
      end
    end else if (werr_clr) begin
      werr_sticky_r <= 1'b0;
      werr_addr_r   <= {ADDR_W{1'b0}};
    end
  end

  assign werr_sticky = werr_sticky_r;
  assign werr_addr   = werr_addr_r;
`endif

  // North side: write ready from registered occupancy, read ready in RESP
  assign n_pready  = reset_n & ((wr_access_s & not_full_s) | (state_r == RESP));
  assign n_prdata  = (state_r == RESP) ? rdata_r : {DATA_W{1'b0}};
  assign n_pslverr = (state_r == RESP) & rerr_r;

  assign s_psel    = s_psel_r;
  assign s_penable = s_penable_r;
  assign s_pwrite  = s_pwrite_r;
  assign s_paddr   = s_paddr_r;
  assign s_pwdata  = s_pwdata_r;
  assign count     = count_s;

endmodule

// File: tb/tb_apb_posted_pipeline.sv
// Scoreboard bench for apb_posted_pipeline: a memory-backed south slave,
// a reference memory updated at north acceptance, and queues of expected
// south writes / north read responses checked by a separate monitor.
module tb_apb_posted_pipeline;
  localparam int AW = 32, DW = 32, DEPTH = 4, DELAY = 16;
  localparam int CW = $clog2(DEPTH) + 1;

  logic clk = 1'b0, reset_n = 1'b1;
  logic n_psel = 1'b0, n_penable = 1'b0, n_pwrite = 1'b0;
  logic [AW-1:0] n_paddr = '0;
  logic [DW-1:0] n_pwdata = '0;
  logic n_pready, n_pslverr, s_psel, s_penable, s_pwrite;
  logic [DW-1:0] n_prdata, s_pwdata;
  logic [AW-1:0] s_paddr;
  logic s_pready = 1'b0, s_pslverr = 1'b0;
  logic [DW-1:0] s_prdata = '0;
  logic [CW-1:0] count;
`ifdef APB_PIPE_WERR_EN
  logic werr_clr = 1'b0, werr_sticky;
  logic [AW-1:0] werr_addr;
`endif

  apb_posted_pipeline #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .DELAY(DELAY)) dut (
    .clk(clk), .reset_n(reset_n),
    .n_psel(n_psel), .n_penable(n_penable), .n_pwrite(n_pwrite),
    .n_paddr(n_paddr), .n_pwdata(n_pwdata),
    .n_pready(n_pready), .n_prdata(n_prdata), .n_pslverr(n_pslverr),
    .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
    .s_paddr(s_paddr), .s_pwdata(s_pwdata),
    .s_pready(s_pready), .s_prdata(s_prdata), .s_pslverr(s_pslverr),
`ifdef APB_PIPE_WERR_EN
    .werr_clr(werr_clr), .werr_sticky(werr_sticky), .werr_addr(werr_addr),
`endif
    .count(count)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0, fails = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model and slave memory (16 words, indexed by addr[5:2])
  logic [31:0] ref_mem [16];
  logic [31:0] slv_mem [16];
  function automatic logic err_of(input logic [31:0] a);
    return (a[7:0] == 8'h20) || (a[7:0] == 8'h40) || (a[7:0] == 8'h80);
  endfunction

  typedef struct packed { logic [31:0] addr; logic [31:0] data; logic [31:0] t; } wr_t;
  typedef struct packed { logic [31:0] data; logic err; } rd_t;
  wr_t south_q[$];
  rd_t read_q[$];

  // South slave: optional wait states, memory backed, error by address
  int stall_req = 0, stall_left = 0;
  bit rand_stall = 0, in_acc = 0;
  always @(negedge clk) begin
    if (s_psel && s_penable) begin
      if (!in_acc) begin
        in_acc = 1;
        stall_left = rand_stall ? int'($urandom_range(0, 3)) : stall_req;
      end
      if (stall_left > 0) begin
        stall_left--; s_pready = 0; s_pslverr = 0; s_prdata = '0;
      end else begin
        s_pready = 1;
        s_pslverr = err_of(s_paddr);
        if (s_pwrite) slv_mem[s_paddr[5:2]] = s_pwdata;
        else s_prdata = slv_mem[s_paddr[5:2]];
      end
    end else begin
      in_acc = 0; s_pready = 0; s_pslverr = 0; s_prdata = '0;
    end
  end

  // Monitor: checks south transfers and north read responses
  int unsigned last_setup_cyc = 0, last_done_cyc = 0, first_pop_cyc = 0;
  int south_seen = 0, acc_len = 0, cur_acc_len = 0, max_count = 0;
  logic [31:0] prev_addr = '0, prev_data = '0;
  logic prev_write = 1'b0, prev_act = 1'b0;
  wr_t mw;
  rd_t mr;
  always begin
    @(negedge clk); #1;
    if (s_psel && !s_penable) begin
      south_seen++; last_setup_cyc = cyc; cur_acc_len = 0;
      if (s_pwrite) begin
        if (south_q.size() == 0) chk("unexpected_south_write", 1, 0);
        else chk("write_delay_min", 64'(cyc >= south_q[0].t + DELAY), 1);
      end else begin
        chk("read_after_drain", south_q.size(), 0);
      end
    end
    if (s_psel && s_penable) begin
      cur_acc_len++;
      if (prev_act)
        chk("access_stable", 64'(s_paddr == prev_addr && s_pwdata == prev_data && s_pwrite == prev_write), 1);
      if (s_pready) begin
        last_done_cyc = cyc; acc_len = cur_acc_len;
        if (s_pwrite) begin
          if (first_pop_cyc == 0) first_pop_cyc = cyc;
          if (south_q.size() == 0) chk("unexpected_south_write", 1, 0);
          else begin
            mw = south_q.pop_front();
            chk("south_addr", s_paddr, mw.addr);
            chk("south_data", s_pwdata, mw.data);
          end
        end
      end
    end
    prev_act = s_psel; prev_addr = s_paddr; prev_data = s_pwdata; prev_write = s_pwrite;
    if (int'(count) > max_count) max_count = int'(count);
    if (n_psel && n_penable && n_pready) begin
      if (n_pwrite) chk("n_pslverr_write", n_pslverr, 0);
      else if (read_q.size() == 0) chk("unexpected_read_resp", 1, 0);
      else begin
        mr = read_q.pop_front();
        chk("n_prdata", n_prdata, mr.data);
        chk("n_pslverr_read", n_pslverr, mr.err);
      end
    end
  end

  // North master tasks
  task automatic apb_write(input logic [31:0] a, input logic [31:0] d, output int unsigned t_acc);
    bit ok = 0;
    @(negedge clk);
    n_psel = 1; n_penable = 0; n_pwrite = 1; n_paddr = a; n_pwdata = d;
    @(negedge clk);
    n_penable = 1;
    for (int i = 0; i < 2000 && !ok; i++) begin
      #1;
      if (n_pready) ok = 1;
      else @(negedge clk);
    end
    t_acc = cyc;
    if (ok) begin
      south_q.push_back('{addr: a, data: d, t: cyc});
      ref_mem[a[5:2]] = d;
    end else chk("write_timeout", 0, 1);
  endtask

  task automatic apb_read(input logic [31:0] a, output int unsigned t_start, output int unsigned t_resp);
    bit ok = 0;
    read_q.push_back('{data: ref_mem[a[5:2]], err: err_of(a)});
    @(negedge clk);
    n_psel = 1; n_penable = 0; n_pwrite = 0; n_paddr = a;
    @(negedge clk);
    n_penable = 1; t_start = cyc;
    for (int i = 0; i < 2000 && !ok; i++) begin
      #1;
      if (n_pready) ok = 1;
      else @(negedge clk);
    end
    t_resp = cyc;
    if (!ok) chk("read_timeout", 0, 1);
  endtask

  task automatic apb_idle();
    @(negedge clk);
    n_psel = 0; n_penable = 0; n_pwrite = 0;
  endtask

  task automatic wait_south_idle(input string name);
    bit done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk); #1;
      if (south_q.size() == 0 && !s_psel) done = 1;
    end
    if (!done) chk(name, 0, 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int unsigned t0, t1, ts, tr, acc[6];
  int snap;
  logic [31:0] v;
  bit got;
  initial begin
    for (int i = 0; i < 16; i++) begin
      v = $urandom; slv_mem[i] = v; ref_mem[i] = v;
    end
    slv_mem[8] = 32'hDEAD_BEEF; ref_mem[8] = 32'hDEAD_BEEF;
    #1 reset_n = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_ctrl", {n_pready, n_pslverr, s_psel, s_penable, s_pwrite, count}, 0);
    chk("reset_s_paddr", s_paddr, 0);
    chk("reset_s_pwdata", s_pwdata, 0);
    chk("reset_n_prdata", n_prdata, 0);
    @(negedge clk); reset_n = 1;
    repeat (5) @(negedge clk);
    chk("idle_after_reset", south_seen, 0);

    // Single write: exact SETUP/ACCESS timing and count return
    apb_write(32'h10, 32'hA5A5_A5A5, t0);
    apb_idle();
    while (cyc < t0 + 18) @(negedge clk);
    #1;
    chk("t1_setup_cycle", last_setup_cyc, t0 + 16);
    chk("t1_access_cycle", last_done_cyc, t0 + 17);
    chk("t1_count_zero", count, 0);

    // Five back-to-back writes into a 4-deep FIFO
    first_pop_cyc = 0; max_count = 0;
    for (int k = 1; k <= 5; k++) apb_write(32'(k * 4), 32'h1000_0000 + 32'(k), acc[k]);
    apb_idle();
    wait_south_idle("full_drain_timeout");
    chk("full_stall_release", acc[5], first_pop_cyc + 1);
    chk("count_peak", max_count, 4);

    // Ten wait states on the south port
    stall_req = 10;
    apb_write(32'h08, $urandom, t0);
    apb_idle();
    wait_south_idle("stall_timeout");
    chk("stall_access_len", acc_len, 11);
    stall_req = 0;

    // Two writes then a read of 0x20 that fails on the south side
    apb_write(32'h30, $urandom, t0);
    apb_write(32'h34, $urandom, t0);
    apb_read(32'h20, ts, tr);
    chk("read_deadbeef", n_prdata, 32'hDEAD_BEEF);
    chk("read_err_direct", n_pslverr, 1);
    apb_idle();

    // Minimum read latency with an empty FIFO
    apb_read(32'h0C, ts, tr);
    chk("read_latency", tr - ts, 3);
    apb_idle();

    // Reset in the middle of a stalled ACCESS with three entries queued
    stall_req = 60;
    for (int k = 0; k < 3; k++) apb_write(32'(k * 4 + 16'h24), $urandom, t0);
    apb_idle();
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk); #1;
      if (s_psel && s_penable) got = 1;
    end
    chk("reach_access", got, 1);
    chk("pre_reset_count", count, 3);
    #2 reset_n = 0;
    #1;
    chk("async_reset_ctrl", {n_pready, n_pslverr, s_psel, s_penable, s_pwrite, count}, 0);
    chk("async_reset_addr", s_paddr, 0);
    chk("async_reset_data", s_pwdata, 0);
    south_q.delete();
    stall_req = 0;
    for (int i = 0; i < 16; i++) ref_mem[i] = slv_mem[i];
    @(negedge clk); reset_n = 1;
    snap = south_seen;
    repeat (40) @(negedge clk);
    chk("no_south_after_reset", south_seen - snap, 0);

    // Randomised mix against the reference memory
    rand_stall = 1;
    for (int n = 0; n < 60; n++) begin
      v = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      if ($urandom_range(0, 3) == 0) apb_read(v, ts, tr);
      else apb_write(v, $urandom, t0);
      if ($urandom_range(0, 3) == 0) begin
        apb_idle();
        repeat ($urandom_range(0, 20)) @(negedge clk);
      end
    end
    apb_idle();
    wait_south_idle("random_drain_timeout");
    chk("scoreboard_drained", south_q.size() + read_q.size(), 0);
    rand_stall = 0;

`ifdef APB_PIPE_WERR_EN
    @(negedge clk); werr_clr = 1;
    @(negedge clk); werr_clr = 0;
    #1 chk("werr_cleared", werr_sticky, 0);
    apb_write(32'h40, $urandom, t0);
    apb_write(32'h80, $urandom, t0);
    apb_idle();
    wait_south_idle("werr_drain_timeout");
    chk("werr_sticky", werr_sticky, 1);
    chk("werr_first_addr", werr_addr, 32'h40);
    apb_write(32'h20, $urandom, t0);
    apb_idle();
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk); #1;
      if (s_psel && s_penable && s_pready) got = 1;
    end
    chk("werr_reach_done", got, 1);
    werr_clr = 1;
    @(negedge clk); werr_clr = 0;
    #1 chk("werr_set_beats_clr", werr_sticky, 1);
    @(negedge clk); werr_clr = 1;
    @(negedge clk); werr_clr = 0;
    #1 chk("werr_clr_sticky", werr_sticky, 0);
    chk("werr_clr_addr", werr_addr, 0);
`endif

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
